// File: rtl/mic_volume_meter_pkg.sv
// Shared widths, default quantizer settings and display helpers for the mic volume path.
package mic_pkg;

  localparam int unsigned MIC_BITS   = 12;
  localparam int unsigned LEVEL_BITS = 4;
  localparam int unsigned LED_COUNT  = 16;

  localparam logic [MIC_BITS-1:0] DEFAULT_BASELINE = 12'd2048;
  localparam int unsigned         DEFAULT_SHIFT    = 7;

  // Thermometer bar: LED i lights while i is below the level, so led[15] stays dark.
  function automatic logic [LED_COUNT-1:0] thermo16(input logic [LEVEL_BITS-1:0] lvl);
    logic [LED_COUNT-1:0] bar;
    bar = 16'h0000;
    for (int i = 0; i < LED_COUNT; i++) begin
      bar[i] = (i < int'(lvl));
    end
    return bar;
  endfunction

  // Subtraction only happens above the baseline, so the 12-bit difference never wraps.
  function automatic logic [LEVEL_BITS-1:0] quant_level(input logic [MIC_BITS-1:0] p,
                                                        input logic [MIC_BITS-1:0] base,
                                                        input int unsigned         shift);
    logic [MIC_BITS-1:0] q;
    q = 12'd0;
    if (p > base) begin
      q = (p - base) >> shift;
      if (q > 12'd15) begin
        quant_level = 4'd15;
      end else begin
        quant_level = q[LEVEL_BITS-1:0];
      end
    end else begin
      quant_level = 4'd0;
    end
  endfunction

endpackage

// File: rtl/mic_volume_meter_if.sv
// Volume result bus from the meter to the display stages.
interface mic_volume_meter_if;
  import mic_pkg::*;

  logic [LEVEL_BITS-1:0] level;
  logic                  level_valid;
  logic [LED_COUNT-1:0]  led;

  modport master (output level, output level_valid, output led);
  modport slave  (input level, input level_valid, input led);
endinterface

// File: rtl/mic_volume_meter_edge_sync_pulse.sv
// Three-flop synchronizer with a registered rising-edge one-shot for slow divided clocks.
module edge_sync_pulse (
  input  logic basys_clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic s0_r;
  logic s1_r;
  logic s2_r;
  logic pulse_r;

  // Synchronizer chain and one-shot; a held-high input yields a single pulse.
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      s0_r    <= 1'b0;
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      s0_r    <= async_in;
      s1_r    <= s0_r;
      s2_r    <= s1_r;
      pulse_r <= s1_r & ~s2_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/mic_volume_meter.sv
// Windowed peak detector on 20 kHz mic samples, publishing a 4-bit level and LED bar per window.
module mic_volume_meter
  import mic_pkg::*;
#(
  parameter int unsigned         WINDOW   = 4000,
  parameter logic [MIC_BITS-1:0] BASELINE = DEFAULT_BASELINE,
  parameter int unsigned         SHIFT    = DEFAULT_SHIFT
) (
  input  logic                basys_clock,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic [MIC_BITS-1:0] mic_in,
  output logic                sample_tick,
  mic_volume_meter_if.master  meter
);

  localparam logic [15:0] LAST_COUNT = 16'(WINDOW - 1);

  logic                  sample_tick_s;
  logic [MIC_BITS-1:0]   peak_r;
  logic [15:0]           count_r;
  logic [LEVEL_BITS-1:0] level_r;
  logic                  level_valid_r;
  logic [LED_COUNT-1:0]  led_r;

  logic [MIC_BITS-1:0]   peak_max_s;
  logic                  window_end_s;
  logic [LEVEL_BITS-1:0] quant_s;

  edge_sync_pulse u_sync (
    .basys_clock (basys_clock),
    .reset       (reset),
    .async_in    (sample_clk),
    .pulse       (sample_tick_s)
  );

  // Running peak including the current sample, and its quantized level.
  always_comb begin
    peak_max_s   = peak_r;
    window_end_s = (count_r == LAST_COUNT);
    if (mic_in > peak_r) begin
      peak_max_s = mic_in;
    end else begin
      peak_max_s = peak_r;
    end
    quant_s = quant_level(peak_max_s, BASELINE, SHIFT);
  end

  // Sample capture and window close; state only moves on tick cycles.
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      peak_r        <= 12'd0;
      count_r       <= 16'd0;
      level_r       <= 4'd0;
      level_valid_r <= 1'b0;
      led_r         <= 16'h0000;
    end else begin
      level_valid_r <= 1'b0;
      if (sample_tick_s) begin
        if (window_end_s) begin
          level_r       <= quant_s;
          led_r         <= thermo16(quant_s);
          level_valid_r <= 1'b1;
          peak_r        <= 12'd0;
          count_r       <= 16'd0;
        end else begin
          peak_r  <= peak_max_s;
          count_r <= count_r + 16'd1;
        end
      end
    end
  end

  assign sample_tick       = sample_tick_s;
  assign meter.level       = level_r;
  assign meter.level_valid = level_valid_r;
  assign meter.led         = led_r;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Directed bench for mic_volume_meter with WINDOW=4 and a shortened sample_clk period.
module tb_mic_volume_meter;
  import mic_pkg::*;

  logic        basys_clock = 1'b0;
  logic        reset       = 1'b1;
  logic        sample_clk  = 1'b0;
  logic [11:0] mic_in      = 12'd0;
  logic        sample_tick;

  int total = 0;
  int bad   = 0;
  int tick_cnt  = 0;
  int valid_cnt = 0;
  int t0;
  int v0;

  mic_volume_meter_if meter ();

  mic_volume_meter #(.WINDOW(4)) dut (
    .basys_clock (basys_clock),
    .reset       (reset),
    .sample_clk  (sample_clk),
    .mic_in      (mic_in),
    .sample_tick (sample_tick),
    .meter       (meter.master)
  );

  always #5 basys_clock = ~basys_clock;

  always @(posedge basys_clock) begin
    if (sample_tick) tick_cnt <= tick_cnt + 1;
    if (meter.level_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_sample(input logic [11:0] v);
    @(negedge basys_clock);
    mic_in     = v;
    sample_clk = 1'b1;
    repeat (12) @(negedge basys_clock);
    sample_clk = 1'b0;
    repeat (12) @(negedge basys_clock);
  endtask

  initial begin
    // Reset with a sample_clk pulse that must be ignored.
    repeat (2) @(negedge basys_clock);
    sample_clk = 1'b1;
    repeat (2) @(negedge basys_clock);
    sample_clk = 1'b0;
    @(negedge basys_clock);
    check("rst_level", 32'(meter.level), 32'd0);
    check("rst_led", 32'(meter.led), 32'h0000);
    check("rst_valid", 32'(meter.level_valid), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    check("rst_no_ticks", 32'(tick_cnt), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge basys_clock);

    // First sample with tick latency: high during the cycle after edge E+2.
    v0 = valid_cnt;
    mic_in     = 12'd2100;
    sample_clk = 1'b1;
    @(posedge basys_clock); #1;
    @(posedge basys_clock); #1;
    check("tick_e1", 32'(sample_tick), 32'd0);
    @(posedge basys_clock); #1;
    check("tick_e2", 32'(sample_tick), 32'd1);
    @(posedge basys_clock); #1;
    check("tick_width", 32'(sample_tick), 32'd0);
    repeat (10) @(negedge basys_clock);
    sample_clk = 1'b0;
    repeat (12) @(negedge basys_clock);
    send_sample(12'd3000);
    send_sample(12'd2500);
    check("w1_no_early_valid", 32'(valid_cnt - v0), 32'd0);
    send_sample(12'd2200);
    check("w1_valid", 32'(valid_cnt - v0), 32'd1);
    check("w1_level", 32'(meter.level), 32'd7);
    check("w1_led", 32'(meter.led), 32'h007F);

    // Full-scale window then an all-below-baseline window.
    v0 = valid_cnt;
    send_sample(12'd4095);
    send_sample(12'd2048);
    send_sample(12'd2048);
    send_sample(12'd2048);
    check("w2_level", 32'(meter.level), 32'd15);
    check("w2_led", 32'(meter.led), 32'h7FFF);
    send_sample(12'd1000);
    send_sample(12'd1500);
    check("w3_hold_level", 32'(meter.level), 32'd15);
    send_sample(12'd2000);
    send_sample(12'd2048);
    check("w3_level", 32'(meter.level), 32'd0);
    check("w3_led", 32'(meter.led), 32'h0000);
    check("w23_valid", 32'(valid_cnt - v0), 32'd2);

    // sample_clk held high: one tick, count advances by exactly one.
    t0 = tick_cnt;
    v0 = valid_cnt;
    @(negedge basys_clock);
    mic_in     = 12'd2560;
    sample_clk = 1'b1;
    repeat (200) @(negedge basys_clock);
    check("hold_one_tick", 32'(tick_cnt - t0), 32'd1);
    sample_clk = 1'b0;
    repeat (12) @(negedge basys_clock);
    send_sample(12'd2048);
    send_sample(12'd2048);
    check("hold_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_sample(12'd2048);
    check("hold_valid", 32'(valid_cnt - v0), 32'd1);
    check("hold_level", 32'(meter.level), 32'd4);
    check("hold_led", 32'(meter.led), 32'h000F);

    // Reset mid-window discards the partial peak.
    send_sample(12'd4000);
    send_sample(12'd4000);
    @(negedge basys_clock);
    reset = 1'b1;
    repeat (5) @(negedge basys_clock);
    reset = 1'b0;
    check("mid_rst_level", 32'(meter.level), 32'd0);
    check("mid_rst_led", 32'(meter.led), 32'h0000);
    v0 = valid_cnt;
    send_sample(12'd2176);
    send_sample(12'd2176);
    send_sample(12'd2176);
    send_sample(12'd2176);
    check("mid_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("mid_rst_new_level", 32'(meter.level), 32'd1);
    check("mid_rst_new_led", 32'(meter.led), 32'h0001);

    // Reset in the exact cycle of the window-closing tick.
    send_sample(12'd4095);
    send_sample(12'd4095);
    send_sample(12'd4095);
    v0 = valid_cnt;
    @(negedge basys_clock);
    sample_clk = 1'b1;
    @(posedge basys_clock);
    @(posedge basys_clock);
    @(posedge basys_clock); #1;
    check("coll_tick_high", 32'(sample_tick), 32'd1);
    @(negedge basys_clock);
    reset = 1'b1;
    @(negedge basys_clock);
    sample_clk = 1'b0;
    repeat (4) @(negedge basys_clock);
    reset = 1'b0;
    repeat (20) @(negedge basys_clock);
    check("coll_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("coll_level", 32'(meter.level), 32'd0);
    check("coll_led", 32'(meter.led), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
